// File: rtl/mem_arbiter.sv
// Purpose: arbitrates one single-ported memory between instruction fetch and data load/store.
// Latency: grant registered one edge after req is sampled; done pulses one edge after mem_ack.
// Backpressure: requesters hold req until done; memory stalls by withholding mem_ack indefinitely.
module mem_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);
  localparam logic [1:0] OWN_NONE    = 2'd0;
  localparam logic [1:0] OWN_FETCH   = 2'd1;
  localparam logic [1:0] OWN_DATA    = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_wait_cnt, w_wait_cnt_nxt;
  logic                r_mem_req, w_mem_req_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic [1:0]          r_owner, w_owner_nxt;
  logic                r_if_done, w_if_done_nxt;
  logic                r_d_done, w_d_done_nxt;
  logic [DATA_W-1:0]   r_if_rdata, w_if_rdata_nxt;
  logic [DATA_W-1:0]   r_d_rdata, w_d_rdata_nxt;
  logic                w_data_wins;

  // State register and fetch-starvation counter; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Next-state, arbitration and next-output decode; data wins unless fetch has waited MAX_WAIT grants.
  always_comb begin
    w_state_nxt     = r_state;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_owner_nxt     = r_owner;
    w_if_done_nxt   = 1'b0;
    w_d_done_nxt    = 1'b0;
    w_if_rdata_nxt  = r_if_rdata;
    w_d_rdata_nxt   = r_d_rdata;
    w_data_wins     = d_req && (!if_req || (r_wait_cnt < LP_MAX_WAIT));

    case (r_state)
      IDLE: begin
        if (w_data_wins) begin
          w_state_nxt     = BUSY_D;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = d_we;
          w_mem_addr_nxt  = d_addr;
          w_mem_wdata_nxt = d_wdata;
          w_owner_nxt     = OWN_DATA;
          // Only a fetch that was actually passed over counts; cannot exceed MAX_WAIT here.
          if (if_req) begin
            w_wait_cnt_nxt = r_wait_cnt + 4'd1;
          end
        end else if (if_req) begin
          w_state_nxt     = BUSY_I;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = 1'b0;
          w_mem_addr_nxt  = if_addr;
          w_mem_wdata_nxt = '0;
          w_owner_nxt     = OWN_FETCH;
          w_wait_cnt_nxt  = 4'd0;
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          w_state_nxt    = DONE;
          w_mem_req_nxt  = 1'b0;
          w_mem_we_nxt   = 1'b0;
          w_owner_nxt    = OWN_NONE;
          w_if_rdata_nxt = mem_rdata;
          w_if_done_nxt  = 1'b1;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          w_state_nxt   = DONE;
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
          w_owner_nxt   = OWN_NONE;
          w_d_rdata_nxt = mem_rdata;
          w_d_done_nxt  = 1'b1;
        end
      end
      DONE: begin
        // Requests and acks are ignored for this one cycle so a stale req cannot re-grant.
        w_state_nxt = IDLE;
        w_owner_nxt = OWN_NONE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Registered outputs so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_owner     <= OWN_NONE;
      r_if_done   <= 1'b0;
      r_d_done    <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_owner     <= w_owner_nxt;
      r_if_done   <= w_if_done_nxt;
      r_d_done    <= w_d_done_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign owner     = r_owner;
  assign if_done   = r_if_done;
  assign d_done    = r_d_done;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;

endmodule
